// File: rtl/spi_irq_pkg.sv
// Shared definitions for the SPI interrupt gateway.
// Contents:
// - Default source count and claim-ID width.
// - Byte addresses of the four-register APB window.
// - Claim/complete state enum.
package spi_irq_pkg;

  localparam int unsigned NUM_IRQ_DEFAULT = 6;
  localparam int unsigned ID_W_DEFAULT    = 3;

  localparam logic [3:0] ADDR_ENABLE   = 4'h0;
  localparam logic [3:0] ADDR_STATUS   = 4'h4;
  localparam logic [3:0] ADDR_CLAIM    = 4'h8;
  localparam logic [3:0] ADDR_COMPLETE = 4'hC;

  typedef enum logic {
    GW_IDLE,
    GW_CLAIMED
  } gw_state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-set-bit priority encoder.
// Ports:
//   i_req   - request vector; bit 0 has the highest priority.
//   o_valid - at least one request is set.
//   o_idx   - index of the lowest set bit (0 when o_valid is low).
module irq_prio_enc #(
  parameter int unsigned Width = 6,
  parameter int unsigned IdxW  = 3
) (
  input  logic [Width-1:0] i_req,
  output logic             o_valid,
  output logic [IdxW-1:0]  o_idx
);

  always_comb begin
    o_idx = '0;
    // Scan from the top down so the lowest set bit is the one that sticks.
    for (int i = Width - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx = IdxW'(i);
      end
    end
    o_valid = |i_req;
  end

endmodule

// File: rtl/spi_irq_gateway.sv
// Bus-side interrupt gateway for the SPI flag block.
// Presents ENABLE/STATUS/CLAIM/COMPLETE over APB-lite and aggregates the
// enabled sticky flags into one level irq. A CLAIM read returns the
// highest-priority pending ID (index+1), pulses its clear, and masks irq
// until COMPLETE is written with the same ID.
// Ports:
//   CLK, nRST                     - clock, asynchronous active-low reset.
//   psel/penable/pwrite/paddr/pwdata, prdata/pready - APB-lite slave.
//   interrupts                    - sticky flags from the flag block.
//   interrupt_enable              - ENABLE register, to the flag block.
//   clear                         - registered one-cycle clear pulses.
//   irq                           - aggregated level interrupt.
module spi_irq_gateway
  import spi_irq_pkg::*;
#(
  parameter int unsigned NUM_IRQ = NUM_IRQ_DEFAULT,
  parameter int unsigned ID_W    = ID_W_DEFAULT
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               psel,
  input  logic               penable,
  input  logic               pwrite,
  input  logic [3:0]         paddr,
  input  logic [31:0]        pwdata,
  output logic [31:0]        prdata,
  output logic               pready,
  input  logic [NUM_IRQ-1:0] interrupts,
  output logic [NUM_IRQ-1:0] interrupt_enable,
  output logic [NUM_IRQ-1:0] clear,
  output logic               irq
);

  gw_state_t          r_state, w_state_d;
  logic [ID_W-1:0]    r_cur_id, w_cur_id_d;
  logic [NUM_IRQ-1:0] r_enable, w_enable_d;
  logic [NUM_IRQ-1:0] r_clear, w_clear_d;

  logic               w_acc, w_wr, w_rd;
  logic [3:0]         w_addr;
  logic [NUM_IRQ-1:0] w_pend;
  logic               w_valid;
  logic [ID_W-1:0]    w_best;
  logic [ID_W-1:0]    w_claim_id;
  logic               w_claim_ok;
  logic               w_unused;

  assign w_acc  = psel & penable;
  assign w_wr   = w_acc & pwrite;
  assign w_rd   = w_acc & ~pwrite;
  assign w_addr = {paddr[3:2], 2'b00};
  assign w_pend = interrupts & r_enable;

  irq_prio_enc #(
    .Width(NUM_IRQ),
    .IdxW (ID_W)
  ) u_prio_enc (
    .i_req  (w_pend),
    .o_valid(w_valid),
    .o_idx  (w_best)
  );

  assign w_claim_id = w_best + ID_W'(1);
  // A claim only takes effect in IDLE with something pending.
  assign w_claim_ok = w_rd && (w_addr == ADDR_CLAIM) && (r_state == GW_IDLE) && w_valid;

  always_comb begin
    w_state_d  = r_state;
    w_cur_id_d = r_cur_id;
    w_enable_d = r_enable;
    w_clear_d  = '0;
    if (w_wr) begin
      case (w_addr)
        ADDR_ENABLE: w_enable_d = pwdata[NUM_IRQ-1:0];
        ADDR_STATUS: w_clear_d  = pwdata[NUM_IRQ-1:0];
        ADDR_COMPLETE: begin
          if (r_state == GW_CLAIMED && pwdata[ID_W-1:0] == r_cur_id) begin
            w_state_d = GW_IDLE;
          end
        end
        default: ;
      endcase
    end
    if (w_claim_ok) begin
      w_clear_d  = NUM_IRQ'(1) << w_best;
      w_cur_id_d = w_claim_id;
      w_state_d  = GW_CLAIMED;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= GW_IDLE;
      r_cur_id <= '0;
      r_enable <= '0;
      r_clear  <= '0;
    end else begin
      r_state  <= w_state_d;
      r_cur_id <= w_cur_id_d;
      r_enable <= w_enable_d;
      r_clear  <= w_clear_d;
    end
  end

  always_comb begin
    prdata = '0;
    if (w_rd) begin
      case (w_addr)
        ADDR_ENABLE: prdata = 32'(r_enable);
        ADDR_STATUS: prdata = 32'(interrupts);
        ADDR_CLAIM:  prdata = w_claim_ok ? 32'(w_claim_id) : 32'd0;
        default:     prdata = '0;
      endcase
    end
  end

  assign pready           = 1'b1;
  assign interrupt_enable = r_enable;
  assign clear            = r_clear;
  assign irq              = (r_state == GW_IDLE) && w_valid;

  assign w_unused = ^{pwdata, paddr[1:0]};

endmodule

// File: tb/tb_spi_irq_gateway.sv
// Self-checking bench for spi_irq_gateway: directed scenarios followed by
// randomized APB traffic, all compared cycle by cycle against a behavioural
// model of the register map and claim/complete protocol.
module tb_spi_irq_gateway;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        psel, penable, pwrite;
  logic [3:0]  paddr;
  logic [31:0] pwdata, prdata;
  logic        pready;
  logic [5:0]  interrupts, interrupt_enable, clear;
  logic        irq;

  always #5 CLK = ~CLK;

  spi_irq_gateway #(
    .NUM_IRQ(6),
    .ID_W   (3)
  ) dut (
    .CLK             (CLK),
    .nRST            (nRST),
    .psel            (psel),
    .penable         (penable),
    .pwrite          (pwrite),
    .paddr           (paddr),
    .pwdata          (pwdata),
    .prdata          (prdata),
    .pready          (pready),
    .interrupts      (interrupts),
    .interrupt_enable(interrupt_enable),
    .clear           (clear),
    .irq             (irq)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state.
  bit          m_claimed;
  int          m_cur_id;
  logic [5:0]  m_en;
  logic [5:0]  m_clear;
  logic [31:0] last_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [5:0] v);
    for (int i = 0; i < 6; i++) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_claimed = 1'b0;
    m_cur_id  = 0;
    m_en      = '0;
    m_clear   = '0;
  endtask

  // One clock cycle with the currently driven inputs: compare at the negedge,
  // advance the model at the posedge, return 1 time unit after it.
  task automatic step();
    logic [5:0]  pend, n_en, n_clear;
    logic [31:0] exp_rd;
    int          b, n_cur;
    bit          acc, n_claimed;
    @(negedge CLK);
    pend   = interrupts & m_en;
    b      = lowest(pend);
    acc    = psel && penable;
    exp_rd = '0;
    if (acc && !pwrite) begin
      case (paddr[3:2])
        2'd0: exp_rd = 32'(m_en);
        2'd1: exp_rd = 32'(interrupts);
        2'd2: if (!m_claimed && b >= 0) exp_rd = 32'(b + 1);
        default: ;
      endcase
    end
    check("irq", 32'(irq), 32'(!m_claimed && pend != 0));
    check("prdata", prdata, exp_rd);
    check("enable", 32'(interrupt_enable), 32'(m_en));
    check("clear", 32'(clear), 32'(m_clear));
    check("pready", 32'(pready), 32'd1);
    last_rd = prdata;

    n_claimed = m_claimed;
    n_cur     = m_cur_id;
    n_en      = m_en;
    n_clear   = '0;
    if (acc && pwrite) begin
      case (paddr[3:2])
        2'd0: n_en = pwdata[5:0];
        2'd1: n_clear = pwdata[5:0];
        2'd3: if (m_claimed && int'(pwdata[2:0]) == m_cur_id) n_claimed = 1'b0;
        default: ;
      endcase
    end
    if (acc && !pwrite && paddr[3:2] == 2'd2 && !m_claimed && b >= 0) begin
      n_clear[b] = 1'b1;
      n_claimed  = 1'b1;
      n_cur      = b + 1;
    end
    @(posedge CLK);
    m_claimed = n_claimed;
    m_cur_id  = n_cur;
    m_en      = n_en;
    m_clear   = n_clear;
    #1;
  endtask

  // Two-phase APB transfer; 'raise' is OR-ed into the flags in the access cycle.
  task automatic apb(input bit wr, input logic [3:0] a, input logic [31:0] d,
                     input logic [5:0] raise);
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = a;
    pwdata  = d;
    step();
    interrupts = interrupts | raise;
    penable    = 1'b1;
    step();
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
  endtask

  initial begin
    nRST       = 1'b0;
    psel       = 1'b0;
    penable    = 1'b0;
    pwrite     = 1'b0;
    paddr      = '0;
    pwdata     = '0;
    interrupts = '0;
    model_reset();
    #3;
    check("rst0_irq", 32'(irq), 32'd0);
    check("rst0_en", 32'(interrupt_enable), 32'd0);
    check("rst0_clear", 32'(clear), 32'd0);
    check("rst0_prdata", prdata, 32'd0);
    #9 nRST = 1'b1;
    @(posedge CLK);
    #1;

    // Claim / complete sequence.
    interrupts = 6'b100100;
    apb(1'b1, 4'h0, 32'h3F, 6'h0);
    check("irq_on", 32'(irq), 32'd1);
    apb(1'b0, 4'h8, 32'h0, 6'h0);
    check("claim3", last_rd, 32'd3);
    check("clr_pulse", 32'(clear), 32'h04);
    check("irq_masked", 32'(irq), 32'd0);
    step();
    interrupts = 6'b100000;
    step();
    check("clr_gone", 32'(clear), 32'h00);
    apb(1'b0, 4'h8, 32'h0, 6'h0);
    check("claim_again0", last_rd, 32'd0);
    apb(1'b1, 4'hC, 32'd5, 6'h0);
    check("cmpl_bad_irq", 32'(irq), 32'd0);
    apb(1'b1, 4'hC, 32'd3, 6'h0);
    check("cmpl_ok_irq", 32'(irq), 32'd1);
    apb(1'b0, 4'h8, 32'h0, 6'h0);
    check("claim6", last_rd, 32'd6);

    // Asynchronous reset while claimed.
    #2 nRST = 1'b0;
    #1;
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_en", 32'(interrupt_enable), 32'd0);
    check("rst_clear", 32'(clear), 32'd0);
    check("rst_prdata", prdata, 32'd0);
    model_reset();
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;
    apb(1'b0, 4'h8, 32'h0, 6'h0);
    check("rst_claim0", last_rd, 32'd0);
    apb(1'b1, 4'h0, 32'h3F, 6'h0);
    apb(1'b0, 4'h8, 32'h0, 6'h0);
    check("rst_idle_claim6", last_rd, 32'd6);
    apb(1'b1, 4'hC, 32'd6, 6'h0);

    // Masked sources.
    interrupts = 6'b111110;
    apb(1'b1, 4'h0, 32'h01, 6'h0);
    check("mask_irq", 32'(irq), 32'd0);
    apb(1'b0, 4'h8, 32'h0, 6'h0);
    check("mask_claim0", last_rd, 32'd0);
    apb(1'b1, 4'h0, 32'h3F, 6'h0);
    check("unmask_irq", 32'(irq), 32'd1);

    // STATUS W1C.
    interrupts = 6'h21;
    apb(1'b1, 4'h4, 32'h21, 6'h0);
    check("w1c_clear", 32'(clear), 32'h21);
    check("w1c_irq", 32'(irq), 32'd1);
    step();
    check("w1c_clear_off", 32'(clear), 32'h00);

    // Flag rising in the claim access cycle.
    interrupts = 6'b010000;
    apb(1'b0, 4'h8, 32'h0, 6'b000001);
    check("race_claim1", last_rd, 32'd1);
    check("race_clear", 32'(clear), 32'h01);
    apb(1'b1, 4'hC, 32'd1, 6'h0);

    // Masking the claimed source does not abort the claim.
    interrupts = 6'b000010;
    apb(1'b0, 4'h8, 32'h0, 6'h0);
    check("claim2", last_rd, 32'd2);
    apb(1'b1, 4'h0, 32'h0, 6'h0);
    check("mask_claimed_irq", 32'(irq), 32'd0);
    apb(1'b1, 4'hC, 32'd2, 6'h0);
    check("cmpl_masked_irq", 32'(irq), 32'd0);
    apb(1'b0, 4'h8, 32'h0, 6'h0);
    check("masked_claim0", last_rd, 32'd0);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      int          op;
      logic [3:0]  lo;
      logic [31:0] d;
      op = $urandom_range(0, 9);
      lo = 4'($urandom_range(0, 3));
      d  = $urandom();
      if ($urandom_range(0, 2) == 0) interrupts = 6'($urandom());
      case (op)
        0, 1: step();
        2: apb(1'b1, 4'h0 | lo, d, 6'h0);
        3: apb(1'b0, 4'($urandom_range(0, 15)), d, 6'h0);
        4: apb(1'b1, 4'h4 | lo, d, 6'h0);
        5, 6: apb(1'b0, 4'h8 | lo, d, 6'($urandom_range(0, 3) == 0 ? $urandom() : 0));
        7, 8: begin
          if ($urandom_range(0, 1) == 1) d = (d & ~32'h7) | 32'(m_cur_id);
          apb(1'b1, 4'hC | lo, d, 6'h0);
        end
        default: apb(1'b1, 4'($urandom_range(0, 15)), d, 6'h0);
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
